// File: rtl/mw93_responder.sv
// mw93_responder: Microwire slave answering 93C46-style (x16) EEPROM commands.
// CS/SK/DI are synchronised into clk; word storage sits behind an external
// synchronous-read memory port (mem_rd -> mem_rdata valid one clk later).
module mw93_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int PROG_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sk,
  input  logic              di,
  output logic              dout,
  output logic              dout_oe,
  output logic              busy,
  output logic              wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int CMD_BITS = ADDR_W + 2;
  localparam int BCW      = $clog2(DATA_W + CMD_BITS + 1);
  localparam int PCW      = $clog2(PROG_CYCLES + 1);

  localparam logic [BCW-1:0]    CMD_LAST  = BCW'(CMD_BITS - 1);
  localparam logic [BCW-1:0]    DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0]    DATA_END  = BCW'(DATA_W);
  localparam logic [BCW-1:0]    BC_ONE    = BCW'(1);
  localparam logic [PCW-1:0]    PROG_LAST = PCW'(PROG_CYCLES - 1);
  localparam logic [PCW-1:0]    PC_ONE    = PCW'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, CMD, READ, WDATA, ARM, PROG, DONE
  } state_t;

  // Synchroniser and edge detect
  logic [2:0] pin_in;
  logic [2:0] sync1_reg, sync2_reg;
  logic       sk_prev_reg;
  logic       cs_s, sk_s, di_s, skr;

  assign pin_in = {cs, sk, di};
  assign cs_s   = sync2_reg[2];
  assign sk_s   = sync2_reg[1];
  assign di_s   = sync2_reg[0];
  assign skr    = sk_s & ~sk_prev_reg;

  // Two-flop synchronisers for CS/SK/DI plus SK history for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sk_prev_reg <= 1'b0;
    end else begin
      sync1_reg   <= pin_in;
      sync2_reg   <= sync1_reg;
      sk_prev_reg <= sk_s;
    end
  end

  // Protocol state
  state_t              state_reg, state_next;
  logic [CMD_BITS-2:0] cmd_sr_reg, cmd_sr_next;
  logic [CMD_BITS-1:0] cmd_shift;
  logic [DATA_W-1:0]   data_sr_reg, data_sr_next;
  logic [BCW-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [PCW-1:0]      prog_cnt_reg, prog_cnt_next;
  logic                bulk_reg, bulk_next;
  logic                seq_pend_reg, seq_pend_next;
  logic                status_pend_reg, status_pend_next;
  logic                rd_dly_reg;
  logic                wen_reg, wen_next;
  logic                busy_reg, busy_next;
  logic                dout_reg, dout_next;
  logic                dout_oe_reg, dout_oe_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                mem_rd_reg, mem_rd_next;
  logic                mem_we_reg, mem_we_next;

  assign cmd_shift = {cmd_sr_reg, di_s};

  // State register and all registered outputs; reset abandons any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cmd_sr_reg      <= '0;
      data_sr_reg     <= '0;
      bit_cnt_reg     <= '0;
      prog_cnt_reg    <= '0;
      bulk_reg        <= 1'b0;
      seq_pend_reg    <= 1'b0;
      status_pend_reg <= 1'b0;
      rd_dly_reg      <= 1'b0;
      wen_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      dout_reg        <= 1'b0;
      dout_oe_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_rd_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cmd_sr_reg      <= cmd_sr_next;
      data_sr_reg     <= data_sr_next;
      bit_cnt_reg     <= bit_cnt_next;
      prog_cnt_reg    <= prog_cnt_next;
      bulk_reg        <= bulk_next;
      seq_pend_reg    <= seq_pend_next;
      status_pend_reg <= status_pend_next;
      rd_dly_reg      <= mem_rd_reg;
      wen_reg         <= wen_next;
      busy_reg        <= busy_next;
      dout_reg        <= dout_next;
      dout_oe_reg     <= dout_oe_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      mem_rd_reg      <= mem_rd_next;
      mem_we_reg      <= mem_we_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next       = state_reg;
    cmd_sr_next      = cmd_sr_reg;
    data_sr_next     = data_sr_reg;
    bit_cnt_next     = bit_cnt_reg;
    prog_cnt_next    = prog_cnt_reg;
    bulk_next        = bulk_reg;
    seq_pend_next    = seq_pend_reg;
    status_pend_next = status_pend_reg;
    wen_next         = wen_reg;
    busy_next        = busy_reg;
    dout_next        = dout_reg;
    dout_oe_next     = dout_oe_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    mem_rd_next      = 1'b0;
    mem_we_next      = 1'b0;

    if (!cs_s && state_reg != PROG && state_reg != ARM) begin
      // Deselect drops any partial command without side effects
      state_next   = IDLE;
      dout_oe_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Ready/busy status is shown while selected after a program op
          dout_oe_next = status_pend_reg;
          if (status_pend_reg) begin
            dout_next = ~busy_reg;
          end
          if (skr && di_s && !busy_reg) begin
            state_next       = CMD;
            bit_cnt_next     = '0;
            status_pend_next = 1'b0;
            dout_oe_next     = 1'b0;
          end
        end

        CMD: begin
          if (skr) begin
            cmd_sr_next  = cmd_shift[CMD_BITS-2:0];
            bit_cnt_next = bit_cnt_reg + BC_ONE;
            if (bit_cnt_reg == CMD_LAST) begin
              mem_addr_next = cmd_shift[ADDR_W-1:0];
              bit_cnt_next  = '0;
              bulk_next     = 1'b0;
              case (cmd_shift[CMD_BITS-1 -: 2])
                2'b10: begin
                  mem_rd_next   = 1'b1;
                  dout_next     = 1'b0;
                  dout_oe_next  = 1'b1;
                  seq_pend_next = 1'b0;
                  state_next    = READ;
                end
                2'b01: state_next = WDATA;
                2'b11: begin
                  data_sr_next = '1;
                  state_next   = ARM;
                end
                default: begin
                  case (cmd_shift[ADDR_W-1 -: 2])
                    2'b11: begin
                      wen_next   = 1'b1;
                      state_next = DONE;
                    end
                    2'b00: begin
                      wen_next   = 1'b0;
                      state_next = DONE;
                    end
                    2'b10: begin
                      data_sr_next = '1;
                      bulk_next    = 1'b1;
                      state_next   = ARM;
                    end
                    default: begin
                      bulk_next  = 1'b1;
                      state_next = WDATA;
                    end
                  endcase
                end
              endcase
            end
          end
        end

        READ: begin
          if (rd_dly_reg) begin
            // Word arrives one clk after mem_rd; on a sequential read its
            // MSB goes straight out because that SK edge already passed
            if (seq_pend_reg) begin
              dout_next     = mem_rdata[DATA_W-1];
              data_sr_next  = {mem_rdata[DATA_W-2:0], 1'b0};
              bit_cnt_next  = BC_ONE;
              seq_pend_next = 1'b0;
            end else begin
              data_sr_next = mem_rdata;
            end
          end else if (skr) begin
            if (bit_cnt_reg == DATA_END) begin
              mem_addr_next = mem_addr_reg + ADDR_ONE;
              mem_rd_next   = 1'b1;
              bit_cnt_next  = '0;
              seq_pend_next = 1'b1;
            end else begin
              dout_next    = data_sr_reg[DATA_W-1];
              data_sr_next = {data_sr_reg[DATA_W-2:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + BC_ONE;
            end
          end
        end

        WDATA: begin
          if (skr) begin
            data_sr_next = {data_sr_reg[DATA_W-2:0], di_s};
            bit_cnt_next = bit_cnt_reg + BC_ONE;
            if (bit_cnt_reg == DATA_LAST) begin
              state_next = ARM;
            end
          end
        end

        ARM: begin
          // Programming launches on deselect, only when write-enabled
          if (!cs_s) begin
            dout_oe_next = 1'b0;
            if (wen_reg) begin
              state_next       = PROG;
              busy_next        = 1'b1;
              status_pend_next = 1'b1;
              prog_cnt_next    = '0;
              mem_we_next      = 1'b1;
              mem_wdata_next   = data_sr_reg;
              mem_addr_next    = bulk_reg ? '0 : mem_addr_reg;
            end else begin
              state_next = IDLE;
            end
          end
        end

        PROG: begin
          // Busy status (dout=0) visible whenever CS is raised during programming
          dout_oe_next = cs_s;
          dout_next    = 1'b0;
          if (mem_we_reg) begin
            if (bulk_reg && mem_addr_reg != ADDR_MAX) begin
              mem_we_next   = 1'b1;
              mem_addr_next = mem_addr_reg + ADDR_ONE;
            end
          end else if (prog_cnt_reg == PROG_LAST) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            prog_cnt_next = prog_cnt_reg + PC_ONE;
          end
        end

        DONE: begin
          state_next = DONE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign dout      = dout_reg;
  assign dout_oe   = dout_oe_reg;
  assign busy      = busy_reg;
  assign wen       = wen_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule
